// File: rtl/traffic_signal_ctrl.sv
// Two-road traffic signal controller with latched pedestrian walk phase
// and a flashing-yellow night mode; all lamp outputs are registered.
module traffic_signal_ctrl #(
   parameter int CNT_W     = 8,
   parameter int GREEN_T   = 8,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int WALK_T    = 5,
   parameter int MIN_GREEN = 3,
   parameter int FLASH_T   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req,
   input  logic       night,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_A = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_B = 3'd5,
      WALK      = 3'd6,
      FLASH     = 3'd7
   } state_t;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   localparam logic [CNT_W-1:0] G_END  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] Y_END  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] R_END  = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] W_END  = CNT_W'(WALK_T - 1);
   localparam logic [CNT_W-1:0] F_END  = CNT_W'(FLASH_T - 1);
   localparam logic [CNT_W-1:0] MG_END = CNT_W'(MIN_GREEN - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             pend, pend_n;
   logic             flash_on, flash_n;
   logic             to_ew, to_ew_n;
   logic             clr;
   logic             g_done;

   function automatic logic [6:0] lamps(input state_t s, input logic f);
      logic [6:0] r;
      r = {RED, RED, 1'b0};
      unique case (s)
         NS_GREEN:  r = {GRN, RED, 1'b0};
         NS_YELLOW: r = {YEL, RED, 1'b0};
         EW_GREEN:  r = {RED, GRN, 1'b0};
         EW_YELLOW: r = {RED, YEL, 1'b0};
         WALK:      r = {RED, RED, 1'b1};
         FLASH:     r = f ? {YEL, YEL, 1'b0} : {OFF, OFF, 1'b0};
         ALL_RED_A,
         ALL_RED_B: r = {RED, RED, 1'b0};
      endcase
      return r;
   endfunction

   // A green may be cut short by a pending request once MIN_GREEN has elapsed.
   assign g_done = (cnt == G_END) || (pend && cnt >= MG_END);

   always_comb begin
      state_n = state;
      cnt_n   = cnt + CNT_W'(1);
      flash_n = flash_on;
      to_ew_n = to_ew;
      clr     = 1'b0;
      unique case (state)
         NS_GREEN:  if (g_done) state_n = NS_YELLOW;
         EW_GREEN:  if (g_done) state_n = EW_YELLOW;
         NS_YELLOW: if (cnt == Y_END) state_n = ALL_RED_A;
         EW_YELLOW: if (cnt == Y_END) state_n = ALL_RED_B;
         ALL_RED_A,
         ALL_RED_B: begin
            if (cnt == R_END) begin
               if (night) begin
                  state_n = FLASH;
                  flash_n = 1'b1;
                  clr     = 1'b1;
               end else if (pend) begin
                  state_n = WALK;
                  to_ew_n = (state == ALL_RED_A);
                  clr     = 1'b1;
               end else begin
                  state_n = (state == ALL_RED_A) ? EW_GREEN : NS_GREEN;
               end
            end
         end
         WALK: begin
            if (cnt == W_END)
               state_n = to_ew ? EW_GREEN : NS_GREEN;
         end
         FLASH: begin
            if (!night) begin
               state_n = ALL_RED_B;
            end else if (cnt == F_END) begin
               flash_n = ~flash_on;
               cnt_n   = '0;
            end
         end
      endcase
      if (state_n != state)
         cnt_n = '0;
      pend_n = (ped_req && state != FLASH) || (pend && !clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ALL_RED_B;
         cnt      <= '0;
         pend     <= 1'b0;
         flash_on <= 1'b1;
         to_ew    <= 1'b0;
         ns_light <= RED;
         ew_light <= RED;
         walk     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         pend     <= pend_n;
         flash_on <= flash_n;
         to_ew    <= to_ew_n;
         {ns_light, ew_light, walk} <= lamps(state_n, flash_n);
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// Randomised bench for traffic_signal_ctrl: a countdown phase model
// predicts lamps per cycle into a scoreboard drained by a monitor.
module tb_traffic_signal_ctrl;

   localparam int GREEN_T   = 8;
   localparam int YELLOW_T  = 3;
   localparam int ALLRED_T  = 2;
   localparam int WALK_T    = 5;
   localparam int MIN_GREEN = 3;
   localparam int FLASH_T   = 2;

   localparam int NSG = 0, NSY = 1, ARA = 2, EWG = 3;
   localparam int EWY = 4, ARB = 5, WK = 6, FL = 7;

   typedef struct packed {
      logic [2:0] ns;
      logic [2:0] ew;
      logic       wk;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, ped_req, night;
   logic [2:0] ns_light, ew_light, phase;
   logic       walk;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   bit   running = 0;

   int ph, left, flash_left;
   bit pend, to_ew, flash;

   traffic_signal_ctrl #(
      .CNT_W(8), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
      .ALLRED_T(ALLRED_T), .WALK_T(WALK_T),
      .MIN_GREEN(MIN_GREEN), .FLASH_T(FLASH_T)
   ) dut (
      .clk(clk), .rst(rst), .ped_req(ped_req), .night(night),
      .ns_light(ns_light), .ew_light(ew_light),
      .walk(walk), .phase(phase)
   );

   always #5 clk = ~clk;

   function automatic int dur(input int p);
      case (p)
         NSG, EWG: return GREEN_T;
         NSY, EWY: return YELLOW_T;
         ARA, ARB: return ALLRED_T;
         WK:       return WALK_T;
         default:  return 1;
      endcase
   endfunction

   function automatic exp_t expect_of();
      exp_t e;
      case (ph)
         NSG:     e = '{3'b001, 3'b100, 1'b0};
         NSY:     e = '{3'b010, 3'b100, 1'b0};
         EWG:     e = '{3'b100, 3'b001, 1'b0};
         EWY:     e = '{3'b100, 3'b010, 1'b0};
         WK:      e = '{3'b100, 3'b100, 1'b1};
         FL:      e = flash ? '{3'b010, 3'b010, 1'b0}
                            : '{3'b000, 3'b000, 1'b0};
         default: e = '{3'b100, 3'b100, 1'b0};
      endcase
      return e;
   endfunction

   // Advance the model by one clock edge with the given inputs.
   task automatic model_step(input bit r, input bit p, input bit n);
      int nxt;
      bit clr;
      if (r) begin
         ph = ARB; left = ALLRED_T; pend = 0;
         flash = 1; flash_left = FLASH_T;
         return;
      end
      nxt = ph;
      clr = 0;
      case (ph)
         NSG, EWG:
            if (left == 1 ||
                (pend && (GREEN_T - left) >= MIN_GREEN - 1))
               nxt = (ph == NSG) ? NSY : EWY;
         NSY: if (left == 1) nxt = ARA;
         EWY: if (left == 1) nxt = ARB;
         ARA, ARB:
            if (left == 1) begin
               if (n) begin
                  nxt = FL; clr = 1;
               end else if (pend) begin
                  nxt = WK; to_ew = (ph == ARA); clr = 1;
               end else begin
                  nxt = (ph == ARA) ? EWG : NSG;
               end
            end
         WK: if (left == 1) nxt = to_ew ? EWG : NSG;
         default:
            if (!n) begin
               nxt = ARB;
            end else begin
               flash_left--;
               if (flash_left == 0) begin
                  flash = !flash;
                  flash_left = FLASH_T;
               end
            end
      endcase
      pend = (p && ph != FL) || (pend && !clr);
      if (nxt != ph) begin
         if (nxt == FL) begin
            flash = 1; flash_left = FLASH_T;
         end
         ph = nxt;
         left = dur(nxt);
      end else if (ph != FL) begin
         left--;
      end
   endtask

   task automatic cyc(input bit r, input bit p, input bit n);
      rst = r; ped_req = p; night = n;
      model_step(r, p, n);
      sb.push_back(expect_of());
      @(negedge clk);
   endtask

   task automatic run(input int k, input bit n);
      for (int i = 0; i < k; i++) cyc(0, 0, n);
   endtask

   // Idle until the model sits in phase p with el cycles elapsed.
   task automatic wait_for(input int p, input int el, input bit n);
      int k;
      k = 0;
      while (!(ph == p && dur(ph) - left == el)) begin
         if (k >= 200) begin
            total++; bad++;
            $display("FAIL wait_phase got=%0d want=%0d", ph, p);
            return;
         end
         cyc(0, 0, n);
         k++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!running) continue;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty t=%0t", $time);
         end else begin
            e = sb.pop_front();
            if ({ns_light, ew_light, walk} !== e) begin
               bad++;
               $display("FAIL lamps t=%0t got=%b_%b_%b want=%b_%b_%b",
                        $time, ns_light, ew_light, walk,
                        e.ns, e.ew, e.wk);
            end
         end
         total++;
         if (ns_light != 3'b100 && ew_light != 3'b100 &&
             !(ns_light == ew_light &&
               (ns_light == 3'b010 || ns_light == 3'b000))) begin
            bad++;
            $display("FAIL safety t=%0t got=%b_%b want=one_red",
                     $time, ns_light, ew_light);
         end
      end
   end

   initial begin : driver
      bit n;
      running = 1;
      cyc(1, 0, 0);
      run(60, 0);
      // Early pedestrian cut and walk towards EW.
      wait_for(NSG, 0, 0);
      cyc(0, 1, 0);
      run(30, 0);
      // Late request, then a request held through the walk.
      wait_for(NSG, 5, 0);
      cyc(0, 1, 0);
      wait_for(WK, 0, 0);
      for (int i = 0; i < WALK_T; i++) cyc(0, 1, 0);
      run(50, 0);
      // Night raised mid EW green.
      wait_for(EWG, 3, 0);
      run(30, 1);
      run(20, 0);
      // Night and pending walk meet at ALL_RED_A.
      wait_for(NSG, 0, 0);
      cyc(0, 1, 0);
      wait_for(ARA, 0, 0);
      run(12, 1);
      run(30, 0);
      // Reset inside WALK and inside FLASH.
      wait_for(NSG, 0, 0);
      cyc(0, 1, 0);
      wait_for(WK, 1, 0);
      cyc(1, 0, 0);
      run(30, 0);
      run(40, 1);
      cyc(1, 0, 0);
      run(30, 0);
      n = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 59) == 0) n = !n;
         cyc($urandom_range(0, 199) == 0,
             $urandom_range(0, 14) == 0, n);
      end
      running = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
